game_ctrl: RTL and testbench

Game-logic controller for the VGA paint board. It turns debounced push-button levels into the `state`, `cursor_x`, `cursor_y` and `board_data` words that the graphics stage renders. It runs a MENU/PLAY/SETTLE state machine, moves a wrap-around cursor over an 8×8 board, and paints 12-bit RGB cells from a fixed 8-entry palette.

---
 rtl/game_ctrl_if.sv | 28 ++
 rtl/game_ctrl.sv | 148 ++++++++++++++
 tb/tb_game_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/game_ctrl_if.sv
// Button and render bus between the paint-board controller and its neighbours.
// The master side drives the debounced button levels and watches the game outputs.
// The slave side (the controller) owns the game outputs.
interface game_ctrl_if;
    logic         btn_up;
    logic         btn_down;
    logic         btn_left;
    logic         btn_right;
    logic         btn_sel;
    logic         btn_col;
    logic         btn_back;
    logic [1:0]   state;
    logic [3:0]   cursor_x;
    logic [3:0]   cursor_y;
    logic [767:0] board_data;
    logic [2:0]   pen_idx;
    logic [7:0]   paint_count;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_sel, btn_col, btn_back,
        input  state, cursor_x, cursor_y, board_data, pen_idx, paint_count
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_sel, btn_col, btn_back,
        output state, cursor_x, cursor_y, board_data, pen_idx, paint_count
    );
endinterface

// File: rtl/game_ctrl.sv
// Game-logic controller for the VGA paint board: MENU/PLAY/SETTLE state machine,
// wrap-around cursor over an 8x8 board and 12-bit RGB painting from a fixed palette.
// All outputs come straight from registers.
module game_ctrl #(
    parameter int MAX_PAINTS    = 64,
    parameter int SETTLE_CYCLES = 200_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    game_ctrl_if.slave bus
);
    localparam int                CNT_W       = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [7:0]        MAX_CNT     = 8'(MAX_PAINTS);

    typedef enum logic [1:0] {
        MENU   = 2'b00,
        PLAY   = 2'b01,
        SETTLE = 2'b10
    } state_t;

    state_t           state;
    logic [2:0]       cur_x;
    logic [2:0]       cur_y;
    logic [767:0]     board;
    logic [2:0]       pen;
    logic [7:0]       paint_count;
    logic [CNT_W-1:0] settle_cnt;

    // Button history; bit order {back, col, sel, right, left, down, up}
    logic [6:0] btn_now;
    logic [6:0] btn_q;
    logic [6:0] press;

    logic       up_p, down_p, left_p, right_p, sel_p, col_p, back_p;
    logic [2:0] next_x;
    logic [2:0] next_y;
    logic [9:0] cell_lsb;
    logic [7:0] count_inc;

    // Fixed 8-entry pen palette, {R,G,B} nibbles
    function automatic logic [11:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = 12'hF00;
            3'd1:    palette = 12'h0F0;
            3'd2:    palette = 12'h00F;
            3'd3:    palette = 12'hFF0;
            3'd4:    palette = 12'h0FF;
            3'd5:    palette = 12'hF0F;
            3'd6:    palette = 12'hFFF;
            default: palette = 12'h888;
        endcase
    endfunction

    assign btn_now = {bus.btn_back, bus.btn_col, bus.btn_sel, bus.btn_right,
                      bus.btn_left, bus.btn_down, bus.btn_up};
    assign press   = btn_now & ~btn_q;

    assign up_p    = press[0];
    assign down_p  = press[1];
    assign left_p  = press[2];
    assign right_p = press[3];
    assign sel_p   = press[4];
    assign col_p   = press[5];
    assign back_p  = press[6];

    // Paint target uses the cursor before any move in the same cycle
    assign cell_lsb  = 10'({cur_y, cur_x}) * 10'd12;
    assign count_inc = paint_count + 8'd1;

    // Next cursor position: each axis independent, opposite presses cancel, 3-bit wrap
    always_comb begin
        next_x = cur_x;
        next_y = cur_y;
        if (right_p && !left_p) begin
            next_x = cur_x + 3'd1;
        end else if (left_p && !right_p) begin
            next_x = cur_x - 3'd1;
        end
        if (down_p && !up_p) begin
            next_y = cur_y + 3'd1;
        end else if (up_p && !down_p) begin
            next_y = cur_y - 3'd1;
        end
    end

    // Game state machine with all registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= MENU;
            cur_x       <= '0;
            cur_y       <= '0;
            board       <= '0;
            pen         <= '0;
            paint_count <= '0;
            settle_cnt  <= '0;
            // History starts high so a button held through reset gives no press
            btn_q       <= '1;
        end else begin
            btn_q <= btn_now;
            case (state)
                MENU: begin
                    if (sel_p) begin
                        state       <= PLAY;
                        board       <= '0;
                        cur_x       <= '0;
                        cur_y       <= '0;
                        paint_count <= '0;
                    end
                end
                PLAY: begin
                    cur_x <= next_x;
                    cur_y <= next_y;
                    if (col_p) begin
                        pen <= pen + 3'd1;
                    end
                    // back wins over sel and throws the paint away
                    if (back_p) begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                    end else if (sel_p) begin
                        board[cell_lsb +: 12] <= palette(pen);
                        paint_count           <= count_inc;
                        if (count_inc == MAX_CNT) begin
                            state      <= SETTLE;
                            settle_cnt <= SETTLE_LOAD;
                        end
                    end
                end
                SETTLE: begin
                    if (sel_p || settle_cnt == '0) begin
                        state <= MENU;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                default: state <= MENU;
            endcase
        end
    end

    assign bus.state       = state;
    assign bus.cursor_x    = {1'b0, cur_x};
    assign bus.cursor_y    = {1'b0, cur_y};
    assign bus.board_data  = board;
    assign bus.pen_idx     = pen;
    assign bus.paint_count = paint_count;
endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus a randomized run against a
// cycle-level game model built from plain integers and an 8x8 cell array.
module tb_game_ctrl;
    localparam int MAXP = 3;
    localparam int SETC = 5;

    localparam logic [6:0] BU = 7'h01;
    localparam logic [6:0] BD = 7'h02;
    localparam logic [6:0] BL = 7'h04;
    localparam logic [6:0] BR = 7'h08;
    localparam logic [6:0] BS = 7'h10;
    localparam logic [6:0] BC = 7'h20;
    localparam logic [6:0] BB = 7'h40;
    localparam logic [6:0] B0 = 7'h00;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    game_ctrl_if bus ();

    game_ctrl #(.MAX_PAINTS(MAXP), .SETTLE_CYCLES(SETC)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference game model
    logic [11:0] pal [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF, 12'h888};
    logic [11:0] m_board [8][8];
    int          m_state, m_x, m_y, m_pen, m_cnt;
    logic [6:0]  m_prev;
    int          cyc, settle_entry;

    task automatic model_step(input logic [6:0] b, input logic r);
        logic [6:0] p;
        if (!r) begin
            m_state = 0; m_x = 0; m_y = 0; m_pen = 0; m_cnt = 0;
            for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) m_board[i][j] = 12'h000;
            m_prev = 7'h7F;
            return;
        end
        p = b & ~m_prev;
        m_prev = b;
        if (m_state == 0) begin
            if (p[4]) begin
                m_state = 1; m_x = 0; m_y = 0; m_cnt = 0;
                for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) m_board[i][j] = 12'h000;
            end
        end else if (m_state == 1) begin
            if (p[6]) begin
                m_state = 2; settle_entry = cyc;
            end else if (p[4]) begin
                m_board[m_x][m_y] = pal[m_pen];
                m_cnt = m_cnt + 1;
                if (m_cnt == MAXP) begin
                    m_state = 2; settle_entry = cyc;
                end
            end
            m_x = (m_x + int'(p[3]) - int'(p[2]) + 8) % 8;
            m_y = (m_y + int'(p[1]) - int'(p[0]) + 8) % 8;
            if (p[5]) m_pen = (m_pen + 1) % 8;
        end else begin
            if (p[4] || (cyc - settle_entry) == SETC) m_state = 0;
        end
    endtask

    function automatic logic [767:0] pack_board();
        logic [767:0] v;
        v = '0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                v[12*(y*8+x) +: 12] = m_board[x][y];
        return v;
    endfunction

    task automatic cycle(input logic [6:0] b, input logic r);
        bus.btn_up    = b[0];
        bus.btn_down  = b[1];
        bus.btn_left  = b[2];
        bus.btn_right = b[3];
        bus.btn_sel   = b[4];
        bus.btn_col   = b[5];
        bus.btn_back  = b[6];
        rstn          = r;
        @(posedge clk);
        cyc++;
        model_step(b, r);
        #1;
    endtask

    task automatic test_reset();
        cycle(BS, 1'b0);
        cycle(BS, 1'b0);
        n_checks++; if (bus.state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %h want 0", bus.state); end
        n_checks++; if (bus.cursor_x !== 4'd0) begin n_fail++; $display("FAIL reset_x got %0d want 0", bus.cursor_x); end
        n_checks++; if (bus.cursor_y !== 4'd0) begin n_fail++; $display("FAIL reset_y got %0d want 0", bus.cursor_y); end
        n_checks++; if (bus.board_data !== 768'd0) begin n_fail++; $display("FAIL reset_board got %h want 0", bus.board_data); end
        n_checks++; if (bus.pen_idx !== 3'd0) begin n_fail++; $display("FAIL reset_pen got %0d want 0", bus.pen_idx); end
        n_checks++; if (bus.paint_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.paint_count); end
        cycle(BS, 1'b1);
        cycle(BS, 1'b1);
        n_checks++; if (bus.state !== 2'b00) begin n_fail++; $display("FAIL held_sel_no_pulse got %h want 0", bus.state); end
        cycle(B0, 1'b1);
        cycle(BS, 1'b1);
        n_checks++; if (bus.state !== 2'b01) begin n_fail++; $display("FAIL menu_to_play got %h want 1", bus.state); end
        n_checks++; if (bus.board_data !== 768'd0) begin n_fail++; $display("FAIL play_entry_board got %h want 0", bus.board_data); end
        n_checks++; if ({bus.cursor_x, bus.cursor_y} !== 8'h00) begin n_fail++; $display("FAIL play_entry_cursor got %h want 00", {bus.cursor_x, bus.cursor_y}); end
    endtask

    task automatic test_wrap_cancel();
        cycle(B0, 1'b1);
        cycle(BL, 1'b1);
        n_checks++; if ({bus.cursor_x, bus.cursor_y} !== 8'h70) begin n_fail++; $display("FAIL wrap_left got %h want 70", {bus.cursor_x, bus.cursor_y}); end
        cycle(B0, 1'b1);
        cycle(BU, 1'b1);
        n_checks++; if ({bus.cursor_x, bus.cursor_y} !== 8'h77) begin n_fail++; $display("FAIL wrap_up got %h want 77", {bus.cursor_x, bus.cursor_y}); end
        cycle(B0, 1'b1);
        cycle(BU | BD, 1'b1);
        n_checks++; if ({bus.cursor_x, bus.cursor_y} !== 8'h77) begin n_fail++; $display("FAIL cancel_up_down got %h want 77", {bus.cursor_x, bus.cursor_y}); end
        cycle(B0, 1'b1);
    endtask

    task automatic test_paint_ordering();
        for (int i = 0; i < 3; i++) begin
            cycle(BR | BD, 1'b1);
            cycle(B0, 1'b1);
        end
        cycle(BD, 1'b1);
        cycle(B0, 1'b1);
        n_checks++; if ({bus.cursor_x, bus.cursor_y, 1'b0, bus.pen_idx} !== 12'h230) begin n_fail++; $display("FAIL paint_setup got %h want 230", {bus.cursor_x, bus.cursor_y, 1'b0, bus.pen_idx}); end
        cycle(BS | BR | BC, 1'b1);
        n_checks++; if (bus.board_data[312 +: 12] !== 12'hF00) begin n_fail++; $display("FAIL paint_cell got %h want F00", bus.board_data[312 +: 12]); end
        n_checks++; if ({bus.cursor_x, bus.cursor_y} !== 8'h33) begin n_fail++; $display("FAIL paint_cursor got %h want 33", {bus.cursor_x, bus.cursor_y}); end
        n_checks++; if (bus.pen_idx !== 3'd1) begin n_fail++; $display("FAIL paint_pen got %0d want 1", bus.pen_idx); end
        n_checks++; if (bus.paint_count !== 8'd1) begin n_fail++; $display("FAIL paint_count got %0d want 1", bus.paint_count); end
        cycle(B0, 1'b1);
    endtask

    task automatic test_count_limit();
        cycle(BB, 1'b1);
        cycle(B0, 1'b1);
        cycle(BS, 1'b1);
        cycle(B0, 1'b1);
        cycle(BS, 1'b1);
        n_checks++; if (bus.state !== 2'b01 || bus.board_data !== 768'd0) begin n_fail++; $display("FAIL new_round got state %h board %h want 1 and 0", bus.state, bus.board_data); end
        for (int i = 1; i <= 3; i++) begin
            cycle(B0, 1'b1);
            cycle(BS, 1'b1);
            n_checks++; if (bus.paint_count !== 8'(i)) begin n_fail++; $display("FAIL limit_count got %0d want %0d", bus.paint_count, i); end
            n_checks++; if (bus.state !== ((i == 3) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL limit_state got %h at paint %0d", bus.state, i); end
        end
        for (int i = 0; i < 4; i++) begin
            cycle(B0, 1'b1);
            n_checks++; if (bus.state !== 2'b10) begin n_fail++; $display("FAIL settle_hold got %h want 2 at %0d", bus.state, i); end
        end
        cycle(B0, 1'b1);
        n_checks++; if (bus.state !== 2'b00) begin n_fail++; $display("FAIL settle_timeout got %h want 0", bus.state); end
        n_checks++; if (bus.board_data !== {756'd0, 12'h0F0}) begin n_fail++; $display("FAIL board_retained got %h", bus.board_data); end
    endtask

    task automatic test_back_priority();
        cycle(BS, 1'b1);
        n_checks++; if (bus.state !== 2'b01) begin n_fail++; $display("FAIL bp_enter got %h want 1", bus.state); end
        cycle(B0, 1'b1);
        cycle(BS, 1'b1);
        cycle(BC, 1'b1);
        cycle(B0, 1'b1);
        cycle(BB | BS, 1'b1);
        n_checks++; if (bus.state !== 2'b10) begin n_fail++; $display("FAIL bp_state got %h want 2", bus.state); end
        n_checks++; if (bus.paint_count !== 8'd1) begin n_fail++; $display("FAIL bp_count got %0d want 1", bus.paint_count); end
        n_checks++; if (bus.board_data !== {756'd0, 12'h0F0}) begin n_fail++; $display("FAIL bp_board got %h", bus.board_data); end
        cycle(B0, 1'b1);
        cycle(BS, 1'b1);
        n_checks++; if (bus.state !== 2'b00) begin n_fail++; $display("FAIL settle_sel_exit got %h want 0", bus.state); end
        cycle(B0, 1'b1);
    endtask

    task automatic test_mid_reset();
        cycle(BS, 1'b1);
        cycle(B0, 1'b1);
        cycle(BS, 1'b1);
        cycle(BR, 1'b1);
        cycle(BS, 1'b1);
        n_checks++; if (bus.paint_count !== 8'd2) begin n_fail++; $display("FAIL mr_count got %0d want 2", bus.paint_count); end
        cycle(B0, 1'b0);
        n_checks++; if ({bus.state, bus.cursor_x, bus.cursor_y, bus.pen_idx, bus.paint_count} !== 21'd0) begin n_fail++; $display("FAIL mr_outputs got %h want 0", {bus.state, bus.cursor_x, bus.cursor_y, bus.pen_idx, bus.paint_count}); end
        n_checks++; if (bus.board_data !== 768'd0) begin n_fail++; $display("FAIL mr_board got %h want 0", bus.board_data); end
        cycle(B0, 1'b1);
    endtask

    task automatic test_random();
        logic [6:0] b;
        logic       r;
        logic [767:0] exp_board;
        for (int n = 0; n < 800; n++) begin
            for (int k = 0; k < 7; k++) b[k] = ($urandom_range(0, 99) < 30);
            r = (n == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
            cycle(b, r);
            exp_board = pack_board();
            n_checks++; if (bus.state !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state cyc %0d got %h want %0d", n, bus.state, m_state); end
            n_checks++; if (bus.cursor_x !== 4'(m_x) || bus.cursor_y !== 4'(m_y)) begin n_fail++; $display("FAIL rnd_cursor cyc %0d got %0d,%0d want %0d,%0d", n, bus.cursor_x, bus.cursor_y, m_x, m_y); end
            n_checks++; if (bus.pen_idx !== 3'(m_pen)) begin n_fail++; $display("FAIL rnd_pen cyc %0d got %0d want %0d", n, bus.pen_idx, m_pen); end
            n_checks++; if (bus.paint_count !== 8'(m_cnt)) begin n_fail++; $display("FAIL rnd_count cyc %0d got %0d want %0d", n, bus.paint_count, m_cnt); end
            n_checks++; if (bus.board_data !== exp_board) begin n_fail++; $display("FAIL rnd_board cyc %0d got %h want %h", n, bus.board_data, exp_board); end
        end
    endtask

    initial begin
        cyc = 0;
        settle_entry = 0;
        test_reset();
        test_wrap_cancel();
        test_paint_ordering();
        test_count_limit();
        test_back_priority();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
